// File: rtl/clk_meas_pkg.sv
// Shared constants for the divided-clock ratio meter: FSM encoding and parameter defaults.
package clk_meas_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARM     = 2'd1;
    localparam logic [1:0] ST_MEASURE = 2'd2;

    localparam int DEFAULT_MAX_RATIO = 1024;
    localparam int MIN_SYNC_STAGES   = 2;

endpackage

// File: rtl/clk_ratio_meter_if.sv
// Result bundle of clk_ratio_meter: enable and clock under test in, measurements out.
interface clk_ratio_meter_if #(
    parameter int RATIO_WIDTH = 32
);
    // valid is a single-cycle strobe with no ready: ratio/lock are sampled in the valid
    // cycle, and high is updated on its own in the falling-edge cycle.
    logic                   meas_en;
    logic                   div_clk;
    logic [RATIO_WIDTH-1:0] ratio;
    logic [RATIO_WIDTH-1:0] high;
    logic                   valid;
    logic                   lock;
    logic                   timeout;

    modport master (
        input  meas_en, div_clk,
        output ratio, high, valid, lock, timeout
    );

    modport slave (
        output meas_en, div_clk,
        input  ratio, high, valid, lock, timeout
    );

endinterface

// File: rtl/clk_ratio_meter_sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous level with registered rise/fall strobes.
module sync_edge_det
    import clk_meas_pkg::*;
#(
    parameter int SYNC_STAGES = MIN_SYNC_STAGES
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync   <= '0;
            r_sync_d <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_sync_d <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];
    assign o_rise = o_sync & ~r_sync_d;
    assign o_fall = ~o_sync & r_sync_d;

endmodule

// File: rtl/clk_ratio_meter.sv
// Recovers period, high time and stability of a divided clock in reference-clock cycles.
module clk_ratio_meter
    import clk_meas_pkg::*;
#(
    parameter int RATIO_WIDTH = 32,
    parameter int SYNC_STAGES = 2,
    parameter int MAX_RATIO   = DEFAULT_MAX_RATIO
) (
    input  logic                   i_ref_clk,
    input  logic                   i_rst_n,
    input  logic                   i_meas_en,
    input  logic                   i_div_clk,
    output logic [RATIO_WIDTH-1:0] o_ratio,
    output logic [RATIO_WIDTH-1:0] o_high,
    output logic                   o_valid,
    output logic                   o_lock,
    output logic                   o_timeout
);

    // Depths below the metastability minimum are raised rather than honoured.
    localparam int EFF_SYNC = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;

    localparam logic [RATIO_WIDTH-1:0] CNT_ONE = RATIO_WIDTH'(1);
    localparam logic [RATIO_WIDTH-1:0] CNT_MAX = RATIO_WIDTH'(MAX_RATIO);
    localparam logic [RATIO_WIDTH-1:0] CNT_TMO = RATIO_WIDTH'(MAX_RATIO - 1);

    logic                   w_div_s;
    logic                   w_rise;
    logic                   w_fall;

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [RATIO_WIDTH-1:0] r_per_cnt;
    logic [RATIO_WIDTH-1:0] r_hi_cnt;
    logic                   r_prev_valid;

    logic [RATIO_WIDTH-1:0] r_ratio;
    logic [RATIO_WIDTH-1:0] r_high;
    logic                   r_valid;
    logic                   r_lock;
    logic                   r_timeout;

    logic                   w_active;
    logic                   w_timeout_hit;
    logic                   w_capture;
    logic                   w_high_cap;

    sync_edge_det #(
        .SYNC_STAGES (EFF_SYNC)
    ) u_sync_edge_det (
        .i_clk   (i_ref_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_div_clk),
        .o_sync  (w_div_s),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    assign w_active = (r_state == ST_ARM) || (r_state == ST_MEASURE);

    // The timeout fires as the period count would reach MAX_RATIO; a rise in that cycle is a capture.
    assign w_timeout_hit = w_active && i_meas_en && !w_rise && (r_per_cnt >= CNT_TMO);
    assign w_capture     = (r_state == ST_MEASURE) && i_meas_en && w_rise;
    assign w_high_cap    = (r_state == ST_MEASURE) && i_meas_en && w_fall;

    always_comb begin
        w_state_nxt = r_state;
        if (!i_meas_en) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:    w_state_nxt = ST_ARM;
                ST_ARM:     w_state_nxt = w_rise ? ST_MEASURE : ST_ARM;
                ST_MEASURE: w_state_nxt = w_timeout_hit ? ST_ARM : ST_MEASURE;
                default:    w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_per_cnt <= '0;
            r_hi_cnt  <= '0;
        end else if (r_state == ST_IDLE) begin
            r_per_cnt <= '0;
            r_hi_cnt  <= '0;
        end else begin
            if (w_rise) begin
                r_per_cnt <= CNT_ONE;
            end else if (w_timeout_hit) begin
                r_per_cnt <= '0;
            end else if (r_per_cnt < CNT_MAX) begin
                r_per_cnt <= r_per_cnt + CNT_ONE;
            end

            if (w_rise) begin
                r_hi_cnt <= CNT_ONE;
            end else if (w_div_s && (r_hi_cnt < CNT_MAX)) begin
                r_hi_cnt <= r_hi_cnt + CNT_ONE;
            end
        end
    end

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ratio      <= '0;
            r_high       <= '0;
            r_valid      <= 1'b0;
            r_lock       <= 1'b0;
            r_timeout    <= 1'b0;
            r_prev_valid <= 1'b0;
        end else begin
            r_valid   <= w_capture;
            r_timeout <= w_timeout_hit;

            if (w_capture) begin
                r_ratio <= r_per_cnt;
            end
            if (w_high_cap) begin
                r_high <= r_hi_cnt;
            end

            // Lock compares against the previous capture, so it needs one capture since arming.
            if (!i_meas_en || w_timeout_hit) begin
                r_lock <= 1'b0;
            end else if (w_capture) begin
                r_lock <= (r_per_cnt == r_ratio) && r_prev_valid;
            end

            if (!i_meas_en || w_timeout_hit || (r_state == ST_IDLE)) begin
                r_prev_valid <= 1'b0;
            end else if (w_capture) begin
                r_prev_valid <= 1'b1;
            end
        end
    end

    assign o_ratio   = r_ratio;
    assign o_high    = r_high;
    assign o_valid   = r_valid;
    assign o_lock    = r_lock;
    assign o_timeout = r_timeout;

endmodule

// File: tb/tb_clk_ratio_meter.sv
// Directed bench for clk_ratio_meter driven by a behavioural clock divider.
module tb_clk_ratio_meter;
    import clk_meas_pkg::*;

    localparam int RW   = 32;
    localparam int MAXR = 16;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    clk_ratio_meter_if #(.RATIO_WIDTH(RW)) mif ();

    logic meas_en   = 1'b0;
    logic div_clk_m = 1'b0;
    assign mif.meas_en = meas_en;
    assign mif.div_clk = div_clk_m;

    clk_ratio_meter #(
        .RATIO_WIDTH (RW),
        .SYNC_STAGES (2),
        .MAX_RATIO   (MAXR)
    ) dut (
        .i_ref_clk (clk),
        .i_rst_n   (rst_n),
        .i_meas_en (mif.meas_en),
        .i_div_clk (mif.div_clk),
        .o_ratio   (mif.ratio),
        .o_high    (mif.high),
        .o_valid   (mif.valid),
        .o_lock    (mif.lock),
        .o_timeout (mif.timeout)
    );

    // ---------------- divider model ----------------
    // High for ratio/2 cycles from each wrap; a new ratio takes effect at the next wrap.
    int   div_cnt    = 0;
    int   cur_ratio  = 2;
    int   next_ratio = 2;
    logic hold       = 1'b0;
    logic hold_val   = 1'b0;

    always @(posedge clk) begin
        if (hold) begin
            div_clk_m <= hold_val;
        end else if (div_cnt + 1 >= cur_ratio) begin
            div_cnt   <= 0;
            cur_ratio <= next_ratio;
            div_clk_m <= 1'b1;
        end else begin
            div_cnt   <= div_cnt + 1;
            div_clk_m <= (div_cnt + 1 < cur_ratio / 2);
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_valid(input int max_cyc, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc && !ok; i++) begin
            @(negedge clk);
            if (mif.valid) ok = 1'b1;
        end
    endtask

    task automatic check_capture(input string tag, input int exp_ratio, input logic exp_lock);
        logic ok;
        wait_valid(16, ok);
        check_eq({tag, "_seen"},  {31'b0, ok}, 32'd1);
        check_eq({tag, "_ratio"}, mif.ratio, 32'(exp_ratio));
        check_eq({tag, "_lock"},  {31'b0, mif.lock}, {31'b0, exp_lock});
        check_eq({tag, "_high"},  mif.high, 32'(exp_ratio / 2));
    endtask

    task automatic run_sweep(input int n);
        meas_en    = 1'b0;
        next_ratio = n;
        repeat (20) @(negedge clk);
        meas_en = 1'b1;
        check_capture($sformatf("sweep%0d_c1", n), n, 1'b0);
        check_capture($sformatf("sweep%0d_c2", n), n, 1'b1);
        check_capture($sformatf("sweep%0d_c3", n), n, 1'b1);
    endtask

    int sweep_tab[4] = '{2, 3, 5, 4};
    int n_valid;
    int n_tmo;
    int n_lock;
    int tmo_t[$];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n   = 1'b0;
        meas_en = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_ratio",   mif.ratio, 32'd0);
        check_eq("rst_high",    mif.high, 32'd0);
        check_eq("rst_valid",   {31'b0, mif.valid}, 32'd0);
        check_eq("rst_lock",    {31'b0, mif.lock}, 32'd0);
        check_eq("rst_timeout", {31'b0, mif.timeout}, 32'd0);
        check_eq("rst_state",   {30'b0, dut.r_state}, {30'b0, ST_IDLE});
        rst_n = 1'b1;

        foreach (sweep_tab[i]) run_sweep(sweep_tab[i]);

        // Enable drop while locked at ratio 4.
        meas_en = 1'b0;
        @(negedge clk);
        check_eq("drop_state", {30'b0, dut.r_state}, {30'b0, ST_IDLE});
        check_eq("drop_lock",  {31'b0, mif.lock}, 32'd0);
        check_eq("drop_ratio", mif.ratio, 32'd4);
        check_eq("drop_valid", {31'b0, mif.valid}, 32'd0);
        repeat (5) @(negedge clk);
        meas_en = 1'b1;
        check_capture("reen_c1", 4, 1'b0);
        check_capture("reen_c2", 4, 1'b1);

        // Ratio change 4 -> 5 applied at the divider's next wrap.
        next_ratio = 5;
        check_capture("chg_c1", 4, 1'b1);
        check_capture("chg_c2", 5, 1'b0);
        check_capture("chg_c3", 5, 1'b1);

        // One-cycle reset pulse in MEASURE.
        rst_n = 1'b0;
        #1;
        check_eq("mrst_ratio",   mif.ratio, 32'd0);
        check_eq("mrst_high",    mif.high, 32'd0);
        check_eq("mrst_valid",   {31'b0, mif.valid}, 32'd0);
        check_eq("mrst_lock",    {31'b0, mif.lock}, 32'd0);
        check_eq("mrst_timeout", {31'b0, mif.timeout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check_capture("mrst_c1", 5, 1'b0);
        check_capture("mrst_c2", 5, 1'b1);

        // Divided clock stuck low: periodic timeouts from ARM.
        meas_en  = 1'b0;
        hold_val = 1'b0;
        hold     = 1'b1;
        repeat (10) @(negedge clk);
        meas_en = 1'b1;
        n_valid = 0;
        n_lock  = 0;
        tmo_t.delete();
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (mif.valid)   n_valid++;
            if (mif.lock)    n_lock++;
            if (mif.timeout) tmo_t.push_back(k);
        end
        check_eq("tmo_count",  32'(tmo_t.size()), 32'd3);
        check_eq("tmo_first",  (tmo_t.size() > 0) ? 32'(tmo_t[0]) : 32'd0, 32'd17);
        check_eq("tmo_period", (tmo_t.size() > 1) ? 32'(tmo_t[1] - tmo_t[0]) : 32'd0, 32'd16);
        check_eq("tmo_valid",  32'(n_valid), 32'd0);
        check_eq("tmo_lock",   32'(n_lock), 32'd0);
        check_eq("tmo_ratio",  mif.ratio, 32'd5);

        // Pass-through divider: the sampled level never toggles.
        meas_en  = 1'b0;
        hold_val = 1'b1;
        repeat (10) @(negedge clk);
        meas_en = 1'b1;
        n_valid = 0;
        n_tmo   = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (mif.valid)   n_valid++;
            if (mif.timeout) n_tmo++;
        end
        check_eq("pass_valid", 32'(n_valid), 32'd0);
        check_eq("pass_tmo",   32'(n_tmo), 32'd2);
        check_eq("pass_ratio", mif.ratio, 32'd5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/clk_ratio_meter.md
# clk_ratio_meter

Measures an incoming divided clock against the reference clock and reports the division ratio in reference-clock cycles. It sits on the `i_ref_clk` domain at the output of `clk_div` and is the checking end of that block: `clk_div` produces `o_div_clk` from a ratio, and this block recovers the ratio, high time and stability from the clock. It is used for on-chip self-check of divider configuration and for bench-free ratio readback.

## Interface
- `RATIO_WIDTH`, default 32: width of the ratio and high-time outputs. Matches the `clk_div` ratio port.
- `SYNC_STAGES`, default 2: synchronizer depth on `i_div_clk`. Must be 2 or more.
- `MAX_RATIO`, default 1024: timeout threshold in ref cycles. Must be less than 2^RATIO_WIDTH.

Ports:
- `i_ref_clk` in 1: reference clock, the only clock.
- `i_rst_n` in 1: reset, asynchronous, active-low.
- `i_meas_en` in 1: measurement enable. Level-sensitive.
- `i_div_clk` in 1: divided clock under test, treated as asynchronous data.
- `o_ratio` out RATIO_WIDTH: last measured period in ref cycles.
- `o_high` out RATIO_WIDTH: last measured high time in ref cycles.
- `o_valid` out 1: one-cycle pulse when `o_ratio` updates.
- `o_lock` out 1: the last two consecutive periods were equal.
- `o_timeout` out 1: one-cycle pulse when no rising edge arrives within MAX_RATIO cycles.

## Operation
- Front end: `i_div_clk` goes through a SYNC_STAGES flop chain, giving `div_s`. A registered copy gives `rise = div_s & ~div_d` and `fall = ~div_s & div_d`.
- Period counter `per_cnt`:
  - loads 1 on `rise`
  - otherwise increments, saturating at MAX_RATIO
- High counter `hi_cnt`:
  - loads 1 on `rise`
  - increments while `div_s` is high, saturating
- FSM states are IDLE, ARM and MEASURE.
  - IDLE: entered when `i_meas_en` is 0. Counters are cleared. Moves to ARM when `i_meas_en` is 1.
  - ARM: waits for the first `rise`. On `rise`, moves to MEASURE; no output update.
  - MEASURE: on `rise`:
    - `o_ratio <= per_cnt` and `o_valid` pulses.
    - `o_lock <= (per_cnt == o_ratio) && prev_valid`, where `prev_valid` means at least one earlier period has been captured since arming.
  - MEASURE: on `fall`, `o_high <= hi_cnt`.
- Timeout: in ARM or MEASURE, if `per_cnt` reaches MAX_RATIO with no `rise`:
  - `o_timeout` pulses and `o_lock` clears.
  - `prev_valid` clears and the FSM returns to ARM.
  - `per_cnt` restarts at 0.
- `i_meas_en` falling, from any state: go to IDLE next cycle. `o_lock` and `prev_valid` clear. `o_ratio` and `o_high` hold their last values. No pulses are generated.
- Simultaneous `rise` and timeout in the same cycle: `rise` wins and is a normal capture.
- Measurable range: ratio 2 to MAX_RATIO-1. Ratio 0 or 1 (pass-through clock, never seen as toggling at ref rate) produces a timeout.

## Timing
- Reset values: `o_ratio`=0, `o_high`=0, `o_valid`=0, `o_lock`=0, `o_timeout`=0. FSM is in IDLE, synchronizer flops are 0.
- Edge latency: a `i_div_clk` transition produced on a ref rising edge appears as `rise`/`fall` SYNC_STAGES+1 cycles later.
- First `o_valid`: on the second synchronized rising edge after arming.
- First `o_lock`=1: on the third synchronized rising edge with a constant ratio. Lock updates together with `o_valid`.
- All outputs are registered. `o_ratio` and `o_high` change only in the `o_valid`/`fall` cycles.
- Reset asserted mid-measurement: all state returns to reset values immediately (asynchronous). After release, operation resumes from IDLE/ARM.

## Structure
- Shared package `clk_meas_pkg` holds:
  - state encoding localparams (IDLE=2'd0, ARM=2'd1, MEASURE=2'd2)
  - the default MAX_RATIO
  - the minimum-SYNC_STAGES constant
- Sub-module `sync_edge_det` contains the synchronizer chain plus rise/fall detection. It is parameterized by SYNC_STAGES and is reusable for other async strobes.
- The top level contains the FSM, both counters and the output registers.

## Test plan
- Ratio sweep: `clk_div` instances at ratios 2, 3, 4, 5 feeding four meters, `i_meas_en`=1. Required response:
  - `o_ratio` = 2, 3, 4, 5 respectively.
  - `o_lock`=1 from the third rising edge.
  - `o_high` equals the divider's high phase in ref cycles, e.g. 1 or 2 for ratio 3.
- Ratio change: switch ratio 4 to 5 mid-stream. Required response:
  - One `o_valid` with a transitional period and `o_lock`=0.
  - Then `o_ratio`=5 with `o_lock` re-asserting after two equal periods.
- Timeout: hold `i_div_clk` at 0, MAX_RATIO=16. Required response:
  - `o_timeout` pulses every 16 cycles while in ARM.
  - `o_lock`=0, `o_ratio` unchanged.
- Ratio 1/0: divider in pass-through mode. Required response: no `o_valid`, periodic `o_timeout`.
- Enable drop: deassert `i_meas_en` while locked at ratio 4. Required response:
  - IDLE next cycle, `o_lock`=0, `o_ratio` holds 4.
  - Re-enable gives first `o_valid` on the second rising edge.
- Reset mid-period: pulse `i_rst_n` low for 1 cycle during MEASURE. Required response:
  - All outputs 0 immediately.
  - After release, a correct `o_ratio` on the second rising edge.
